// File: rtl/refclk_div_pkg.sv
// -----------------------------------------------------------------------------
// refclk_div_pkg
//   Shared constants for the reference-clock / enable-strobe generator.
//   DEFAULT_BW : default width of the terminal-count input and internal counter.
// -----------------------------------------------------------------------------
package refclk_div_pkg;

  localparam int DEFAULT_BW = 8;

endpackage : refclk_div_pkg

// File: rtl/refclk_div.sv
// -----------------------------------------------------------------------------
// refclk_div
//   Programmable reference-clock / enable-strobe generator. Divides clk by
//   (ref_st + 1) and emits one registered, single-cycle pulse on refclk per
//   division period. Peripherals use refclk as a slow tick enable.
//
// Ports
//   clk     in   1   global clock, rising-edge active
//   rst_n   in   1   asynchronous reset, active-HIGH (legacy name)
//   ref_st  in   BW  terminal count; ratio = ref_st + 1 (0 -> /1, 1 -> /2)
//   refclk  out  1   registered pulse, high one clk cycle per period
// -----------------------------------------------------------------------------
module refclk_div
  import refclk_div_pkg::*;
#(
  parameter int BW = DEFAULT_BW  // legal range 1..32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [BW-1:0] ref_st,
  output logic          refclk
);

  logic [BW-1:0] cnt;

  // The compare is ">=" rather than "==" so that lowering ref_st below the
  // current count wraps immediately instead of running through the full
  // counter range. As a consequence cnt never exceeds max(ref_st, old cnt),
  // so the increment cannot overflow.
  //
  // NOTE: the reset is asynchronous and, despite its name, active-high,
  // hence the posedge in the sensitivity list. State is updated with
  // non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt    <= '0;
      refclk <= 1'b0;
    end else if (cnt >= ref_st) begin
      cnt    <= '0;
      refclk <= 1'b1;
    end else begin
      cnt    <= cnt + 1'b1;
      refclk <= 1'b0;
    end
  end

endmodule : refclk_div

// File: tb/tb_refclk_div.sv
// -----------------------------------------------------------------------------
// tb_refclk_div
//   Self-checking bench for refclk_div. Two instances: BW=2 (/2 square wave)
//   and BW=8 (/16, /1, runtime ratio changes, mid-run reset).
//   Expected refclk values are derived from the period arithmetic of each
//   scenario, queued before the clock edge and compared after it.
// -----------------------------------------------------------------------------
module tb_refclk_div;

  typedef struct {
    string tag;
    logic  exp;
    bit    sel8;
  } sb_item_t;

  logic       clk;
  logic       rst2;
  logic       rst8;
  logic [1:0] ref2;
  logic [7:0] ref8;
  logic       refclk2;
  logic       refclk8;

  int checks = 0;
  int errors = 0;
  int rises  = 0;
  sb_item_t exp_q[$];

  refclk_div #(.BW(2)) u_dut2 (
    .clk    (clk),
    .rst_n  (rst2),
    .ref_st (ref2),
    .refclk (refclk2)
  );

  refclk_div #(.BW(8)) u_dut8 (
    .clk    (clk),
    .rst_n  (rst8),
    .ref_st (ref8),
    .refclk (refclk8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (time %0t, limit 100000)", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Queue the expected post-edge value, advance one edge, then compare.
  task automatic step(input string tag, input logic exp, input bit sel8);
    sb_item_t item;
    logic     got;
    exp_q.push_back('{tag: tag, exp: exp, sel8: sel8});
    @(posedge clk);
    #1;
    item = exp_q.pop_front();
    got  = item.sel8 ? refclk8 : refclk2;
    if (got) rises++;
    check(item.tag, {31'd0, got}, {31'd0, item.exp});
  endtask

  // Put dut8 into reset away from the clock edge, load a ratio, release.
  task automatic restart8(input logic [7:0] r);
    @(posedge clk);
    #1;
    rst8 = 1'b1;
    ref8 = r;
    #2;
    rst8  = 1'b0;
    rises = 0;
  endtask

  initial begin
    rst2 = 1'b1;
    rst8 = 1'b1;
    ref2 = 2'd1;
    ref8 = 8'd15;

    // Reset state
    #2;
    check("rst_refclk2", {31'd0, refclk2}, 32'd0);
    check("rst_refclk8", {31'd0, refclk8}, 32'd0);
    check("rst_cnt8", {24'd0, u_dut8.cnt}, 32'd0);

    // BW=2, ref_st=1: 50% square wave, pulse on even edges
    @(posedge clk);
    #1;
    rst2  = 1'b0;
    rises = 0;
    for (int k = 1; k <= 100; k++) begin
      step("div2_wave", (k % 2) == 0, 1'b0);
      if (refclk2) check("div2_ratio", k, 2 * rises);
    end
    check("div2_rises", rises, 50);
    rst2 = 1'b1;

    // BW=8, ref_st=15: one pulse every 16 edges
    restart8(8'd15);
    for (int k = 1; k <= 100; k++) begin
      step("div16_wave", (k % 16) == 0, 1'b1);
      if (refclk8) check("div16_ratio", k, 16 * rises);
    end
    check("div16_rises", rises, 100 / 16);

    // ref_st=0: constantly high from the first edge, counter pinned at 0
    restart8(8'd0);
    check("div1_pre_edge", {31'd0, refclk8}, 32'd0);
    for (int k = 1; k <= 10; k++) begin
      step("div1_wave", 1'b1, 1'b1);
      check("div1_cnt", {24'd0, u_dut8.cnt}, 32'd0);
    end

    // Shorten ratio to 3 while cnt=10: immediate pulse, then period 4
    restart8(8'd15);
    for (int k = 1; k <= 10; k++) step("shrink_pre", 1'b0, 1'b1);
    check("shrink_cnt10", {24'd0, u_dut8.cnt}, 32'd10);
    ref8 = 8'd3;
    for (int j = 1; j <= 20; j++) step("shrink_wave", ((j - 1) % 4) == 0, 1'b1);

    // Lengthen ratio to 31 while cnt=5: next pulse 27 edges later, then period 32
    restart8(8'd15);
    for (int k = 1; k <= 5; k++) step("grow_pre", 1'b0, 1'b1);
    check("grow_cnt5", {24'd0, u_dut8.cnt}, 32'd5);
    ref8 = 8'd31;
    for (int j = 1; j <= 91; j++) begin
      step("grow_wave", (j >= 27) && (((j - 27) % 32) == 0), 1'b1);
      if (j == 26) check("grow_cnt31", {24'd0, u_dut8.cnt}, 32'd31);
    end

    // Asynchronous reset at cnt=7: clears without any clock edge
    restart8(8'd15);
    for (int k = 1; k <= 7; k++) step("mid_pre", 1'b0, 1'b1);
    check("mid_cnt7", {24'd0, u_dut8.cnt}, 32'd7);
    #2;
    rst8 = 1'b1;
    #1;
    check("mid_async_cnt", {24'd0, u_dut8.cnt}, 32'd0);
    check("mid_async_refclk", {31'd0, refclk8}, 32'd0);
    #1;
    rst8 = 1'b0;
    for (int k = 1; k <= 16; k++) step("mid_restart", k == 16, 1'b1);

    // Asynchronous reset while the pulse is high drops it immediately
    #2;
    rst8 = 1'b1;
    #1;
    check("pulse_async_refclk", {31'd0, refclk8}, 32'd0);
    check("pulse_async_cnt", {24'd0, u_dut8.cnt}, 32'd0);

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_refclk_div
